// File: rtl/strobe_serial_tx.sv
// strobe_serial_tx
//   Transmit side of a strobed serial link. A parallel word is accepted on
//   start, shifted out MSB-first on d (nd is its complement), and every bit
//   gets exactly one rising edge on en while d is held stable, so a plain
//   D-flip-flop chain clocked by en captures each bit once. Each bit spends
//   DIV clocks in SETUP (en low) and DIV clocks in STROBE (en high).
//
// Parameters
//   WIDTH  bits per frame (>= 2)
//   DIV    system clocks per strobe phase (>= 1)
// Ports
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   start  frame request, sampled only in IDLE
//   din    frame word, captured when start is accepted
//   d/nd   serial data and its complement (registered)
//   en     strobe, receiver captures d on its rising edge (registered)
//   busy   high while a frame is in progress
//   done   one-cycle pulse at the end of a frame
module strobe_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             d,
  output logic             nd,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [PW-1:0]    phase, phase_n;
  logic [BW-1:0]    bitc, bitc_n;
  logic             nd_n, en_n, busy_n, done_n;

  // d is the top bit of the shift register itself, so it is a flop output
  // and only moves when the register loads or shifts. The final bit is not
  // shifted away, which leaves the LSB of the last frame on d in IDLE.
  assign d = shreg[WIDTH-1];

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    phase_n = phase;
    bitc_n  = bitc;
    en_n    = en;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        en_n   = 1'b0;
        busy_n = 1'b0;
        if (start) begin
          shreg_n = din;
          phase_n = '0;
          bitc_n  = '0;
          busy_n  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          en_n    = 1'b1;
          state_n = STROBE;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      STROBE: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          en_n    = 1'b0;
          if (bitc == BIT_LAST) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            // Next bit appears on the same edge en falls, never while en is high.
            shreg_n = {shreg[WIDTH-2:0], 1'b0};
            bitc_n  = bitc + 1'b1;
            state_n = SETUP;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    nd_n = ~shreg_n[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      phase <= '0;
      bitc  <= '0;
      nd    <= 1'b1;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      phase <= phase_n;
      bitc  <= bitc_n;
      nd    <= nd_n;
      en    <= en_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: doc/strobe_serial_tx.md
# strobe_serial_tx

Transmit side of the strobed serial link whose receiver is a chain of edge-triggered D flip-flops clocked by a strobe line. The block accepts a parallel word on a start request. It shifts the word out MSB-first on `d`, with `nd` as its complement. For each bit it generates one clean rising edge on `en` while `d` is held stable, so any D-flip-flop receiver captures every bit exactly once. It sits between the parallel data source and the link pins.

## Interface
- `WIDTH`, default 8: bits per frame; legal values are 2 and above.
- `DIV`, default 4: system clocks per strobe phase; legal values are 1 and above. Each bit lasts 2*DIV clocks.
- `clk` input, 1 bit: the single system clock. All logic is on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: frame request. It is sampled only while the block is idle.
- `din` input, WIDTH bits: frame word. It is captured in the cycle `start` is accepted.
- `d` output, 1 bit: serial data, registered.
- `nd` output, 1 bit: always the complement of `d`, registered.
- `en` output, 1 bit: strobe, registered. The receiver captures `d` on the rising edge of `en`.
- `busy` output, 1 bit: high while a frame is in progress.
- `done` output, 1 bit: one-cycle pulse marking the end of a frame.

## Operation
- States:
  - IDLE.
  - SETUP: `en` is low and `d` is valid.
  - STROBE: `en` is high and `d` is held.
- Registers:
  - shift register, WIDTH bits.
  - phase counter, ceil(log2(DIV)) bits with a minimum of 1; counts 0..DIV-1.
  - bit counter, ceil(log2(WIDTH)) bits; counts 0..WIDTH-1.
- IDLE with `start`=1:
  - Load `din` into the shift register.
  - Move to SETUP; set `busy`=1 and `d`=`din[WIDTH-1]`.
  - Clear both counters.
- SETUP: after DIV cycles, move to STROBE and set `en`=1. `d` is unchanged.
- STROBE: after DIV cycles, `en` goes to 0.
  - If the bit counter is below WIDTH-1: shift left, present the next bit on `d`, increment the bit counter, and return to SETUP.
  - If the bit counter equals WIDTH-1: move to IDLE, set `busy`=0 and `done`=1 for one cycle.
- `d` changes only on the same clock edge where `en` falls, or on entry to SETUP. It never changes while `en`=1.
- `start` is ignored while `busy`=1. `din` is don't-care outside the accept cycle.
- In IDLE, `d` holds the last transmitted bit (the LSB of the previous frame); `en`=0.
- The `done` cycle is an IDLE cycle. A `start` in that cycle is accepted, giving back-to-back frames with one idle cycle between them.

## Timing
- Reset values: `d`=0, `nd`=1, `en`=0, `busy`=0, `done`=0; state IDLE; counters 0.
- Reset mid-frame: the frame is aborted, and every output takes its reset value at the next edge. No partial strobe is extended. A `start` in the reset cycle is ignored.
- `start` accepted at edge k:
  - `busy`=1 and first `d` valid after edge k+1.
  - First rising edge of `en` at edge k+1+DIV.
  - Bit n rising edge at k+1+DIV+2*DIV*n.
- A frame keeps `busy` high for exactly 2*DIV*WIDTH cycles. `done` is high in the following cycle.
- At the receiver, setup time of `d` to the rising edge of `en` is DIV clocks, and hold time is DIV clocks.
- Exactly WIDTH rising edges of `en` occur per frame; there are no glitches.
- DIV=1: `en` toggles every clock, and the rules above still hold.

## Test plan
- Reset, then idle: with `rst` held 3 cycles then released and no `start`, all outputs hold their reset values for 20 cycles and `en` has no edges.
- Single frame: WIDTH=8, DIV=2, `din`=8'hA5, `start` pulsed 1 cycle.
  - `d` sampled at each `en` rising edge gives 1,0,1,0,0,1,0,1.
  - There are exactly 8 rising edges; `busy` is high for 32 cycles; `done` pulses once, in cycle 33 after acceptance.
  - `nd` equals ~`d` on every cycle.
- Back-to-back frames: `din`=8'hFF, then `start` asserted in the `done` cycle with `din`=8'h00.
  - The second frame starts one cycle after `done`.
  - The 16 captured bits are eight 1s followed by eight 0s.
- Start while busy: pulse `start` with `din`=8'h3C in the middle of a frame carrying 8'hC3. The captured word is 8'hC3, and no extra frame follows.
- Reset mid-frame: assert `rst` while `en`=1 during bit 4.
  - Next cycle: `en`=0, `busy`=0, `done`=0.
  - A new frame carrying 8'h81 after reset transmits correctly.
- Receiver loopback: an 8-stage D-flip-flop shift chain clocked by `en` with data input `d`, across 50 random `din` values with WIDTH=8 and DIV=1 and DIV=3. The chain contents equal `din` after each `done`.
